gpio_bank: RTL and testbench

GPIO_BANK -- requirements
Module: gpio_bank

---
 rtl/gpio_bank_if.sv | 13 +
 rtl/gpio_bank.sv | 121 ++++++++++++
 tb/tb_gpio_bank.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/gpio_bank_if.sv
// CPU-side register bus for gpio_bank: select, strobes, index, write data and read data.
// Strobes are single-cycle and only meaningful while sel is high; rdata is combinational.
interface gpio_bank_if;
    logic        sel;
    logic        wr;
    logic        rd;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, output wr, output rd, output addr, output wdata, input rdata);
    modport slave  (input sel, input wr, input rd, input addr, input wdata, output rdata);
endinterface

// File: rtl/gpio_bank.sv
// GPIO bank: output latch, output enables, synchronised and debounced inputs,
// and edge-triggered sticky status with a level interrupt.
module gpio_bank #(
    parameter int WIDTH       = 8,
    parameter int DB_CYCLES   = 25000,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    gpio_bank_if.slave       bus,
    output logic             irq,
    input  logic [WIDTH-1:0] pin_in,
    output logic [WIDTH-1:0] pin_out,
    output logic [WIDTH-1:0] pin_oe
);
    localparam logic [15:0] TICK_AT = 16'(DB_CYCLES - 1);

    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] oe_q, oe_d;
    logic [WIDTH-1:0] rise_en_q, rise_en_d;
    logic [WIDTH-1:0] fall_en_q, fall_en_d;
    logic [WIDTH-1:0] status_q, status_d;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] samp_q, samp_d;
    logic [WIDTH-1:0] deb_q, deb_d;
    logic [WIDTH-1:0] deb_dly_q;
    logic [15:0]      cnt_q, cnt_d;

    logic             we;
    logic             tick;
    logic [WIDTH-1:0] wd;
    logic [WIDTH-1:0] sync;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] fall;
    logic [WIDTH-1:0] w1c;
    logic [WIDTH-1:0] rd_word;

    assign we   = bus.sel & bus.wr;
    assign wd   = bus.wdata[WIDTH-1:0];
    assign sync = sync_q[SYNC_STAGES-1];
    assign tick = (cnt_q == TICK_AT);
    assign rise = deb_q & ~deb_dly_q;
    assign fall = ~deb_q & deb_dly_q;

    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        w1c       = '0;
        if (we) begin
            case (bus.addr)
                3'd0:    out_d     = wd;
                3'd1:    oe_d      = wd;
                3'd2:    out_d     = out_q | wd;
                3'd3:    out_d     = out_q & ~wd;
                3'd4:    rise_en_d = wd;
                3'd5:    fall_en_d = wd;
                3'd6:    w1c       = wd;
                default: ;
            endcase
        end
        // New events are ORed in after the clear so a same-cycle event survives the W1C.
        status_d = (status_q & ~w1c) | (rise & rise_en_q) | (fall & fall_en_q);
    end

    always_comb begin
        cnt_d  = tick ? 16'd0 : cnt_q + 16'd1;
        diff   = sync ^ samp_q;
        samp_d = tick ? sync : samp_q;
        deb_d  = tick ? ((deb_q & diff) | (sync & ~diff)) : deb_q;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            samp_q    <= '0;
            deb_q     <= '0;
            deb_dly_q <= '0;
            cnt_q     <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            samp_q    <= samp_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            cnt_q     <= cnt_d;
            sync_q[0] <= pin_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
        end
    end

    always_comb begin
        rd_word = '0;
        case (bus.addr)
            3'd0:    rd_word = deb_q;
            3'd1:    rd_word = oe_q;
            3'd2:    rd_word = out_q;
            3'd3:    rd_word = out_q;
            3'd4:    rd_word = rise_en_q;
            3'd5:    rd_word = fall_en_q;
            3'd6:    rd_word = status_q;
            default: rd_word = '0;
        endcase
        bus.rdata = '0;
        if (bus.sel) bus.rdata[WIDTH-1:0] = rd_word;
    end

    assign irq     = |status_q;
    assign pin_out = out_q;
    assign pin_oe  = oe_q;
endmodule

// File: tb/tb_gpio_bank.sv
// Self-checking bench for gpio_bank (WIDTH=8, DB_CYCLES=4, SYNC_STAGES=2) with a
// register-level reference model and a read-data scoreboard.
module tb_gpio_bank;
  logic       clk;
  logic       rst;
  logic       irq;
  logic [7:0] pin_in;
  logic [7:0] pin_out;
  logic [7:0] pin_oe;

  gpio_bank_if bus ();

  gpio_bank #(.WIDTH(8), .DB_CYCLES(4), .SYNC_STAGES(2)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .irq     (irq),
    .pin_in  (pin_in),
    .pin_out (pin_out),
    .pin_oe  (pin_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  // Reference model: architectural register contents.
  logic [7:0] m_out, m_oe, m_rise, m_fall, m_status, m_deb;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd0:    return {24'd0, m_deb};
      3'd1:    return {24'd0, m_oe};
      3'd2:    return {24'd0, m_out};
      3'd3:    return {24'd0, m_out};
      3'd4:    return {24'd0, m_rise};
      3'd5:    return {24'd0, m_fall};
      3'd6:    return {24'd0, m_status};
      default: return 32'd0;
    endcase
  endfunction

  function automatic void model_reset();
    m_out = 0; m_oe = 0; m_rise = 0; m_fall = 0; m_status = 0; m_deb = 0;
  endfunction

  function automatic void model_write(input logic [2:0] a, input logic [31:0] d);
    logic [7:0] v;
    v = d[7:0];
    case (a)
      3'd0: m_out = v;
      3'd1: m_oe = v;
      3'd2: m_out = m_out | v;
      3'd3: m_out = m_out & ~v;
      3'd4: m_rise = v;
      3'd5: m_fall = v;
      3'd6: m_status = m_status & ~v;
      default: ;
    endcase
  endfunction

  // Monitor: every selected read strobe is compared against the oldest expectation.
  always @(negedge clk) begin
    if (rst && bus.sel && bus.rd) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rdata: read seen with no expectation queued at %0t", $time);
      end else begin
        check("rdata", bus.rdata, exp_q.pop_front());
      end
    end
  end

  task automatic bus_idle();
    bus.sel = 0; bus.wr = 0; bus.rd = 0; bus.addr = 0; bus.wdata = 0;
  endtask

  task automatic wr_reg(input logic [2:0] a, input logic [31:0] d, input logic s);
    @(posedge clk); #1;
    bus.sel = s; bus.wr = 1; bus.rd = 0; bus.addr = a; bus.wdata = d;
    @(posedge clk); #1;
    bus_idle();
    if (s) model_write(a, d);
  endtask

  task automatic rd_reg(input logic [2:0] a);
    @(posedge clk); #1;
    bus.sel = 1; bus.wr = 0; bus.rd = 1; bus.addr = a;
    exp_q.push_back(model_read(a));
    @(posedge clk); #1;
    bus_idle();
  endtask

  // Drive a new pad value, wait for DEB to follow, then apply edge rules to the model.
  task automatic settle(input logic [7:0] val);
    int lat;
    bit ok;
    logic [7:0] r, f;
    pin_in = val;
    ok = 0;
    lat = 0;
    bus.sel = 1; bus.addr = 3'd0;
    for (int n = 1; n <= 14; n++) begin
      @(posedge clk); #1;
      if (!ok && bus.rdata[7:0] == val) begin
        ok = 1;
        lat = n;
      end
    end
    bus_idle();
    checks++;
    if (!ok || lat > 10) begin
      errors++;
      $display("FAIL deb_latency: DEB=0x%0h after %0d cycles, required 0x%0h within 10", bus.rdata[7:0], lat, val);
    end
    r = val & ~m_deb;
    f = ~val & m_deb;
    m_status = m_status | (r & m_rise) | (f & m_fall);
    m_deb = val;
  endtask

  logic [2:0]  ra;
  logic [31:0] rdv;
  bit found;

  initial begin
    bus_idle();
    pin_in = 8'h00;
    rst = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pin_out", {24'd0, pin_out}, 32'd0);
    check("reset_pin_oe", {24'd0, pin_oe}, 32'd0);
    check("reset_irq", {31'd0, irq}, 32'd0);
    rst = 1;
    for (int i = 0; i < 8; i++) rd_reg(3'(i));

    // Register map basics.
    wr_reg(3'd0, 32'hA5, 1);
    wr_reg(3'd1, 32'h0F, 1);
    wr_reg(3'd2, 32'h30, 1);
    wr_reg(3'd3, 32'h05, 1);
    #1;
    check("pin_out_map", {24'd0, pin_out}, 32'hB0);
    check("pin_oe_map", {24'd0, pin_oe}, 32'h0F);
    for (int i = 0; i < 4; i++) rd_reg(3'(i));

    // Random register traffic with static pads.
    for (int i = 0; i < 40; i++) begin
      ra = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 1) == 0)
        wr_reg(ra, $urandom, ($urandom_range(0, 3) != 0));
      else
        rd_reg(ra);
    end
    check("rand_pin_out", {24'd0, pin_out}, {24'd0, m_out});
    check("rand_pin_oe", {24'd0, pin_oe}, {24'd0, m_oe});
    wr_reg(3'd6, 32'hFF, 1);
    wr_reg(3'd4, 32'h01, 1);
    wr_reg(3'd5, 32'h00, 1);

    // Rising edge on pin 0 latches STATUS and raises irq; W1C clears it.
    settle(8'h01);
    rd_reg(3'd6);
    rd_reg(3'd0);
    check("irq_after_rise", {31'd0, irq}, {31'd0, |m_status});
    wr_reg(3'd6, 32'h01, 1);
    rd_reg(3'd6);
    check("irq_after_w1c", {31'd0, irq}, {31'd0, |m_status});

    // Short glitch on pin 1 is rejected even with all edges enabled.
    wr_reg(3'd4, 32'hFF, 1);
    wr_reg(3'd5, 32'hFF, 1);
    @(posedge clk); #1;
    pin_in[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    pin_in[1] = 1'b0;
    repeat (12) @(posedge clk);
    rd_reg(3'd0);
    rd_reg(3'd6);

    // Same-cycle W1C and fall event on pin 7: the event wins.
    wr_reg(3'd4, 32'h80, 1);
    wr_reg(3'd5, 32'h80, 1);
    settle(8'h81);
    rd_reg(3'd6);
    pin_in[7] = 1'b0;
    found = 0;
    bus.sel = 1; bus.addr = 3'd0;
    for (int n = 0; n < 14 && !found; n++) begin
      @(posedge clk); #1;
      if (!bus.rdata[7]) found = 1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL fall_detect: DEB[7] still 1 after 14 cycles, required 0");
    end
    bus.wr = 1; bus.addr = 3'd6; bus.wdata = 32'h80;
    @(posedge clk); #1;
    bus_idle();
    m_status = (m_status & ~8'h80) | 8'h80;
    m_deb[7] = 1'b0;
    rd_reg(3'd6);
    check("irq_set_wins", {31'd0, irq}, 32'd1);
    wr_reg(3'd6, 32'h80, 1);
    rd_reg(3'd6);

    // Reset mid-debounce with OUT=0xFF and STATUS=0x3.
    wr_reg(3'd4, 32'h03, 1);
    wr_reg(3'd5, 32'h00, 1);
    settle(8'h00);
    settle(8'h03);
    rd_reg(3'd6);
    wr_reg(3'd0, 32'hFF, 1);
    wr_reg(3'd1, 32'hFF, 1);
    pin_in = 8'hFF;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    check("rst_pin_out", {24'd0, pin_out}, 32'd0);
    check("rst_pin_oe", {24'd0, pin_oe}, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 1; i < 7; i++) rd_reg(3'(i));
    settle(8'hFF);
    rd_reg(3'd0);
    rd_reg(3'd6);
    check("post_rst_irq", {31'd0, irq}, 32'd0);

    // Unselected writes and addr 7 writes change nothing; unselected reads return 0.
    wr_reg(3'd1, 32'h5A, 1);
    wr_reg(3'd0, 32'h3C, 1);
    for (int i = 0; i < 7; i++) wr_reg(3'(i), $urandom, 0);
    wr_reg(3'd7, $urandom, 1);
    for (int i = 0; i < 8; i++) rd_reg(3'(i));
    check("nosel_pin_out", {24'd0, pin_out}, 32'h3C);
    @(posedge clk); #1;
    bus.sel = 0; bus.rd = 1; bus.addr = 3'd1;
    #1;
    rdv = bus.rdata;
    check("nosel_rdata", rdv, 32'd0);
    bus_idle();

    repeat (3) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
